bus_decoder: RTL and testbench

//  Sits between the 68000 bus and the memory/IO device controllers. It

---
 rtl/bus_decoder_if.sv | 23 ++
 rtl/bus_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_bus_decoder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_decoder_if.sv
// 68000-side bus bundle seen by the address decoder: CPU strobes and address in,
// device enables, bus error and overlay status out.
interface bus_decoder_if;
   logic        as_n;
   logic [22:0] addr;
   logic        rw;
   logic        dtack_in;
   logic        rom_en;
   logic        ram_en;
   logic        io_en;
   logic        berr;
   logic        overlay;

   modport master (
      output as_n, addr, rw, dtack_in,
      input  rom_en, ram_en, io_en, berr, overlay
   );

   modport slave (
      input  as_n, addr, rw, dtack_in,
      output rom_en, ram_en, io_en, berr, overlay
   );
endinterface

// File: rtl/bus_decoder.sv
// 68000 address decoder: synchronises AS, decodes A[23:20] into device enables,
// applies the boot ROM overlay and raises berr on write-to-ROM or unanswered cycles.

module bus_decoder_chk #(
   parameter int CNT_W   = 7,
   parameter int TIMEOUT = 64
) (
   input logic             clk,
   input logic             reset_n,
   input logic             i_rom_en,
   input logic             i_ram_en,
   input logic             i_io_en,
   input logic             i_berr,
   input logic [CNT_W-1:0] i_wd
);
   a_en_onehot : assert property (@(posedge clk) disable iff (!reset_n)
      $onehot0({i_rom_en, i_ram_en, i_io_en}));
   a_en_berr   : assert property (@(posedge clk) disable iff (!reset_n)
      !(i_berr && (i_rom_en || i_ram_en || i_io_en)));
   a_wd_range  : assert property (@(posedge clk) disable iff (!reset_n)
      i_wd <= CNT_W'(TIMEOUT - 1));
endmodule

module bus_decoder #(
   parameter int BOOT_CYCLES = 4,
   parameter int TIMEOUT     = 64,
   parameter int CNT_W       = 7
) (
   input logic          clk,
   input logic          reset_n,
   bus_decoder_if.slave bus
);
   localparam int                BOOT_W   = $clog2(BOOT_CYCLES + 1);
   localparam logic [BOOT_W-1:0] BOOT_MAX = BOOT_W'(BOOT_CYCLES);
   localparam logic [CNT_W-1:0]  WD_LAST  = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_FAULT  = 2'd3;

   localparam logic [1:0] RG_NONE = 2'd0;
   localparam logic [1:0] RG_RAM  = 2'd1;
   localparam logic [1:0] RG_IO   = 2'd2;
   localparam logic [1:0] RG_ROM  = 2'd3;

   // Region of A[23:20]; the overlay steals region 0 for the reset vector fetch
   function automatic logic [1:0] region_of(input logic [3:0] i_nib, input logic i_ovl);
      logic [1:0] v_rg;
      case (i_nib)
         4'h0:                                  v_rg = i_ovl ? RG_ROM : RG_RAM;
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: v_rg = RG_RAM;
         4'hE:                                  v_rg = RG_IO;
         4'hF:                                  v_rg = RG_ROM;
         default:                               v_rg = RG_NONE;
      endcase
      return v_rg;
   endfunction

   logic              r_as_meta;
   logic              r_as_s;
   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_wd;
   logic [BOOT_W-1:0] r_boot;
   logic              r_overlay;
   logic              r_rom_en;
   logic              r_ram_en;
   logic              r_io_en;
   logic              r_berr;

   logic [1:0]        w_region;
   logic [1:0]        w_state_nxt;
   logic [CNT_W-1:0]  w_wd_nxt;
   logic [BOOT_W-1:0] w_boot_nxt;
   logic              w_overlay_nxt;
   logic              w_rom_nxt;
   logic              w_ram_nxt;
   logic              w_io_nxt;
   logic              w_berr_nxt;
   logic              w_cycle_done;
   logic              w_unused_addr;

   // addr/rw are stable while AS is low, so they are used unsynchronised in DECODE
   assign w_region      = region_of(bus.addr[22:19], r_overlay);
   assign w_unused_addr = ^bus.addr[18:0];

   // Next-state, watchdog and registered-output decisions of the bus-cycle FSM
   always_comb begin
      w_state_nxt  = r_state;
      w_wd_nxt     = r_wd;
      w_rom_nxt    = r_rom_en;
      w_ram_nxt    = r_ram_en;
      w_io_nxt     = r_io_en;
      w_berr_nxt   = r_berr;
      w_cycle_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_as_s) begin
               w_state_nxt = ST_DECODE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DECODE: begin
            if ((w_region == RG_ROM) && !bus.rw) begin
               w_state_nxt = ST_FAULT;
               w_berr_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_ACTIVE;
               w_wd_nxt    = {CNT_W{1'b0}};
               w_rom_nxt   = (w_region == RG_ROM);
               w_ram_nxt   = (w_region == RG_RAM);
               w_io_nxt    = (w_region == RG_IO);
            end
         end
         ST_ACTIVE: begin
            // Strobe release wins over dtack and timeout in the same cycle
            if (!r_as_s) begin
               w_state_nxt  = ST_IDLE;
               w_rom_nxt    = 1'b0;
               w_ram_nxt    = 1'b0;
               w_io_nxt     = 1'b0;
               w_cycle_done = 1'b1;
            end else if (bus.dtack_in) begin
               w_state_nxt = ST_ACTIVE;
            end else if (r_wd == WD_LAST) begin
               w_state_nxt = ST_FAULT;
               w_rom_nxt   = 1'b0;
               w_ram_nxt   = 1'b0;
               w_io_nxt    = 1'b0;
               w_berr_nxt  = 1'b1;
            end else begin
               w_wd_nxt = r_wd + CNT_W'(1);
            end
         end
         ST_FAULT: begin
            if (!r_as_s) begin
               w_state_nxt  = ST_IDLE;
               w_berr_nxt   = 1'b0;
               w_cycle_done = 1'b1;
            end else begin
               w_state_nxt = ST_FAULT;
               w_berr_nxt  = 1'b1;
               w_rom_nxt   = 1'b0;
               w_ram_nxt   = 1'b0;
               w_io_nxt    = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_wd_nxt    = {CNT_W{1'b0}};
            w_rom_nxt   = 1'b0;
            w_ram_nxt   = 1'b0;
            w_io_nxt    = 1'b0;
            w_berr_nxt  = 1'b0;
         end
      endcase
   end

   // Saturating count of completed bus cycles; overlay drops on the edge it saturates
   always_comb begin
      if (w_cycle_done && (r_boot != BOOT_MAX)) begin
         w_boot_nxt = r_boot + BOOT_W'(1);
      end else begin
         w_boot_nxt = r_boot;
      end
      w_overlay_nxt = r_overlay && (w_boot_nxt != BOOT_MAX);
   end

   // State, synchroniser and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_as_meta <= 1'b0;
         r_as_s    <= 1'b0;
         r_state   <= ST_IDLE;
         r_wd      <= {CNT_W{1'b0}};
         r_boot    <= {BOOT_W{1'b0}};
         r_overlay <= 1'b1;
         r_rom_en  <= 1'b0;
         r_ram_en  <= 1'b0;
         r_io_en   <= 1'b0;
         r_berr    <= 1'b0;
      end else begin
         r_as_meta <= ~bus.as_n;
         r_as_s    <= r_as_meta;
         r_state   <= w_state_nxt;
         r_wd      <= w_wd_nxt;
         r_boot    <= w_boot_nxt;
         r_overlay <= w_overlay_nxt;
         r_rom_en  <= w_rom_nxt;
         r_ram_en  <= w_ram_nxt;
         r_io_en   <= w_io_nxt;
         r_berr    <= w_berr_nxt;
      end
   end

   assign bus.rom_en  = r_rom_en;
   assign bus.ram_en  = r_ram_en;
   assign bus.io_en   = r_io_en;
   assign bus.berr    = r_berr;
   assign bus.overlay = r_overlay;

   bus_decoder_chk #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_chk (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_rom_en (r_rom_en),
      .i_ram_en (r_ram_en),
      .i_io_en  (r_io_en),
      .i_berr   (r_berr),
      .i_wd     (r_wd)
   );
endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: directed boot/IO/timeout/fault/reset scenarios
// plus random bus cycles compared edge by edge against an interval-based model.
module tb_bus_decoder;
   localparam int BOOT    = 4;
   localparam int TIMEOUT = 64;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   m_boot   = 0;
   logic [4:0] tr [0:127];

   bus_decoder_if bif ();

   bus_decoder #(
      .BOOT_CYCLES (BOOT),
      .TIMEOUT     (TIMEOUT),
      .CNT_W       (7)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif)
   );

   always #5 clk = ~clk;

   function automatic logic [22:0] a_of(input logic [23:0] byte_addr);
      return byte_addr[23:1];
   endfunction

   // Expected {overlay,berr,io,ram,rom} after edge k of a cycle whose as_n fell just before edge 0
   function automatic logic [4:0] model_out(input int k, input logic [22:0] a, input logic r,
                                            input int dtack_at, input int release_at, input int boot_before);
      logic [3:0] nib;
      logic ovl, rom, ram, io, fault_wr, stuck, en_on, berr_on, ovl_now;
      int drop, t_edge;
      nib      = a[22:19];
      ovl      = (boot_before < BOOT);
      rom      = (nib == 4'hF) || ((nib == 4'h0) && ovl);
      ram      = (nib <= 4'h7) && !rom;
      io       = (nib == 4'hE);
      drop     = release_at + 3;
      t_edge   = 3 + TIMEOUT;
      fault_wr = rom && !r;
      stuck    = !fault_wr && (release_at >= TIMEOUT + 1) && ((dtack_at < 0) || (dtack_at >= t_edge));
      en_on    = (k >= 3) && (k < drop) && !fault_wr && !(stuck && (k >= t_edge));
      berr_on  = (k < drop) && ((fault_wr && (k >= 3)) || (stuck && (k >= t_edge)));
      ovl_now  = (k < drop) ? ovl : (boot_before + 1 < BOOT);
      return {ovl_now, berr_on, io && en_on, ram && en_on, rom && en_on};
   endfunction

   task automatic run_cycle(input logic [22:0] a, input logic r, input int dtack_at,
                            input int release_at, input int total);
      bif.addr     = a;
      bif.rw       = r;
      bif.dtack_in = 1'b0;
      bif.as_n     = 1'b0;
      for (int k = 0; k < total; k++) begin
         @(posedge clk); #1;
         tr[k] = {bif.overlay, bif.berr, bif.io_en, bif.ram_en, bif.rom_en};
         if (k == dtack_at) bif.dtack_in = 1'b1;
         if (k == release_at) begin
            bif.as_n     = 1'b1;
            bif.dtack_in = 1'b0;
         end
      end
      bif.as_n     = 1'b1;
      bif.dtack_in = 1'b0;
      if (m_boot < BOOT) m_boot++;
   endtask

   task automatic test_reset();
      logic [4:0] got;
      #2 reset_n = 1'b0;
      #1 got = {bif.overlay, bif.berr, bif.io_en, bif.ram_en, bif.rom_en};
      n_checks++;
      if (got !== 5'b10000) $display("FAIL reset_async got=%b exp=%b", got, 5'b10000);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 got = {bif.overlay, bif.berr, bif.io_en, bif.ram_en, bif.rom_en};
      n_checks++;
      if (got !== 5'b10000) $display("FAIL reset_idle got=%b exp=%b", got, 5'b10000);
      else n_pass++;
      m_boot = 0;
   endtask

   task automatic test_boot();
      logic [4:0] exp;
      int b0;
      for (int c = 0; c < 5; c++) begin
         b0 = m_boot;
         run_cycle(23'd0, 1'b1, 4, 5, 11);
         for (int k = 0; k < 11; k++) begin
            exp = model_out(k, 23'd0, 1'b1, 4, 5, b0);
            n_checks++;
            if (tr[k] !== exp) $display("FAIL boot c=%0d k=%0d got=%b exp=%b", c, k, tr[k], exp);
            else n_pass++;
         end
         n_checks++;
         if (tr[3][1:0] !== ((c < 4) ? 2'b01 : 2'b10))
            $display("FAIL boot_target c=%0d got=%b exp=%b", c, tr[3][1:0], (c < 4) ? 2'b01 : 2'b10);
         else n_pass++;
         n_checks++;
         if (tr[8][4] !== (c < 3)) $display("FAIL boot_overlay c=%0d got=%b exp=%b", c, tr[8][4], c < 3);
         else n_pass++;
      end
   endtask

   task automatic test_io_read();
      logic [22:0] a;
      logic [4:0] exp;
      logic berr_seen;
      int b0;
      a = a_of(24'hE00010);
      b0 = m_boot;
      run_cycle(a, 1'b1, 5, 7, 13);
      berr_seen = 1'b0;
      for (int k = 0; k < 13; k++) begin
         exp = model_out(k, a, 1'b1, 5, 7, b0);
         berr_seen = berr_seen | tr[k][3];
         n_checks++;
         if (tr[k] !== exp) $display("FAIL io k=%0d got=%b exp=%b", k, tr[k], exp);
         else n_pass++;
      end
      n_checks++;
      if ({tr[2][2], tr[3][2], tr[9][2], tr[10][2]} !== 4'b0110)
         $display("FAIL io_edges got=%b exp=%b", {tr[2][2], tr[3][2], tr[9][2], tr[10][2]}, 4'b0110);
      else n_pass++;
      n_checks++;
      if (berr_seen !== 1'b0) $display("FAIL io_berr got=%b exp=0", berr_seen);
      else n_pass++;
   endtask

   task automatic test_timeout();
      logic [22:0] a;
      logic [4:0] exp;
      int b0;
      a = a_of(24'h900000);
      b0 = m_boot;
      run_cycle(a, 1'b1, -1, 70, 76);
      for (int k = 0; k < 76; k++) begin
         exp = model_out(k, a, 1'b1, -1, 70, b0);
         n_checks++;
         if (tr[k] !== exp) $display("FAIL timeout k=%0d got=%b exp=%b", k, tr[k], exp);
         else n_pass++;
      end
      n_checks++;
      if ({tr[66][3], tr[67][3], tr[72][3], tr[73][3]} !== 4'b0110)
         $display("FAIL timeout_berr got=%b exp=%b", {tr[66][3], tr[67][3], tr[72][3], tr[73][3]}, 4'b0110);
      else n_pass++;
   endtask

   task automatic test_rom_write();
      logic [22:0] a;
      logic [4:0] exp;
      logic rom_seen;
      int b0;
      a = a_of(24'hF00000);
      b0 = m_boot;
      run_cycle(a, 1'b0, -1, 6, 12);
      rom_seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         exp = model_out(k, a, 1'b0, -1, 6, b0);
         rom_seen = rom_seen | tr[k][0];
         n_checks++;
         if (tr[k] !== exp) $display("FAIL romwr k=%0d got=%b exp=%b", k, tr[k], exp);
         else n_pass++;
      end
      n_checks++;
      if ({tr[2][3], tr[3][3], rom_seen} !== 3'b010)
         $display("FAIL romwr_berr got=%b exp=%b", {tr[2][3], tr[3][3], rom_seen}, 3'b010);
      else n_pass++;
   endtask

   task automatic test_release_race();
      logic [22:0] a;
      logic [4:0] exp;
      logic berr_seen;
      int b0, rel;
      a = a_of(24'h900000);
      for (int v = 0; v < 2; v++) begin
         rel = 64 + v;
         b0 = m_boot;
         run_cycle(a, 1'b1, -1, rel, rel + 8);
         berr_seen = 1'b0;
         for (int k = 0; k < rel + 8; k++) begin
            exp = model_out(k, a, 1'b1, -1, rel, b0);
            berr_seen = berr_seen | tr[k][3];
            n_checks++;
            if (tr[k] !== exp) $display("FAIL race rel=%0d k=%0d got=%b exp=%b", rel, k, tr[k], exp);
            else n_pass++;
         end
         n_checks++;
         if (berr_seen !== (v == 1)) $display("FAIL race_berr rel=%0d got=%b exp=%b", rel, berr_seen, v == 1);
         else n_pass++;
      end
   endtask

   task automatic test_dtack_hold();
      logic [22:0] a;
      logic [4:0] exp;
      int b0;
      a = a_of(24'hE00000);
      b0 = m_boot;
      run_cycle(a, 1'b1, 60, 80, 86);
      for (int k = 0; k < 86; k++) begin
         exp = model_out(k, a, 1'b1, 60, 80, b0);
         n_checks++;
         if (tr[k] !== exp) $display("FAIL dtack_hold k=%0d got=%b exp=%b", k, tr[k], exp);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [22:0] a;
      logic [4:0] exp;
      logic [3:0] nib;
      logic r;
      int b0, rel, dt;
      for (int i = 0; i < 40; i++) begin
         nib = 4'($urandom_range(0, 15));
         a   = {nib, 19'($urandom)};
         r   = 1'($urandom_range(0, 1));
         rel = int'($urandom_range(3, 20));
         dt  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(3, rel));
         b0  = m_boot;
         run_cycle(a, r, dt, rel, rel + 6);
         for (int k = 0; k < rel + 6; k++) begin
            exp = model_out(k, a, r, dt, rel, b0);
            n_checks++;
            if (tr[k] !== exp)
               $display("FAIL random i=%0d a=%h rw=%b k=%0d got=%b exp=%b", i, a, r, k, tr[k], exp);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] got;
      logic [4:0] exp;
      logic [22:0] a;
      a = a_of(24'h100000);
      bif.addr = a;
      bif.rw   = 1'b1;
      bif.as_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 n_checks++;
      if (bif.ram_en !== 1'b1) $display("FAIL mid_ram got=%b exp=1", bif.ram_en);
      else n_pass++;
      #2 reset_n = 1'b0;
      #1 got = {bif.overlay, bif.berr, bif.io_en, bif.ram_en, bif.rom_en};
      n_checks++;
      if (got !== 5'b10000) $display("FAIL mid_reset got=%b exp=%b", got, 5'b10000);
      else n_pass++;
      bif.as_n = 1'b1;
      @(posedge clk);
      #1 reset_n = 1'b1;
      m_boot = 0;
      repeat (3) @(posedge clk);
      #1 run_cycle(23'd0, 1'b1, 4, 5, 11);
      for (int k = 0; k < 11; k++) begin
         exp = model_out(k, 23'd0, 1'b1, 4, 5, 0);
         n_checks++;
         if (tr[k] !== exp) $display("FAIL rearm k=%0d got=%b exp=%b", k, tr[k], exp);
         else n_pass++;
      end
   endtask

   initial begin
      bif.as_n     = 1'b1;
      bif.addr     = 23'd0;
      bif.rw       = 1'b1;
      bif.dtack_in = 1'b0;
      test_reset();
      test_boot();
      test_io_read();
      test_timeout();
      test_rom_write();
      test_release_race();
      test_dtack_hold();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
